// File: rtl/seg7_scan_if.sv
// Display-side signal bundle for seg7_scan.
//   master : owner of the display contents (drives data/dp_in/blank/lz_en, sees pin outputs)
//   slave  : the scanner itself (samples contents, drives seg/dp/an/frame)
// DIGITS must match the DIGITS parameter of the connected seg7_scan.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic [4*DIGITS-1:0] data;   // packed nibbles, digit 0 in bits [3:0]
  logic [DIGITS-1:0]   dp_in;  // decimal point request per digit
  logic [DIGITS-1:0]   blank;  // force digit dark
  logic                lz_en;  // leading-zero suppression enable
  logic [6:0]          seg;    // segments a..g at bits 6..0 (physical level)
  logic                dp;     // decimal point of enabled digit (physical level)
  logic [DIGITS-1:0]   an;     // one-hot digit enable (physical level)
  logic                frame;  // one-cycle pulse on every snapshot load

  modport master (
    output data, dp_in, blank, lz_en,
    input  seg, dp, an, frame
  );

  modport slave (
    input  data, dp_in, blank, lz_en,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment display scanner.
// Snapshots the display contents once per scan frame, decodes the selected nibble, and walks a
// one-hot digit enable across DIGITS positions, holding each for REFRESH_DIV cycles.
// Ports:
//   clk - system clock, all state on rising edge
//   rst - synchronous active-high reset
//   bus - seg7_scan_if slave: data/dp_in/blank/lz_en in, seg/dp/an/frame out (all registered)
module seg7_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int unsigned DivW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [DivW-1:0]     div_q, div_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  // Low for the first cycle out of reset; that cycle takes the initial snapshot.
  logic                started_q;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dpin_q;
  logic [DIGITS-1:0]   blank_q;
  logic                lz_q;
  logic                frame_q;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick, wrap, load, zero_run, dark;
  logic [DIGITS-1:0]   supp;
  logic [3:0]          cur_nib;

  always_comb begin
    tick = started_q && (div_q == DivLast);
    wrap = tick && (idx_q == IdxLast);
    load = !started_q || wrap;

    // Prescaler is held on the snapshot cycle so digit 0 gets a full slot after startup.
    div_d = '0;
    idx_d = idx_q;
    if (started_q) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // A digit is suppressed while it and everything above it are zero; blank bits are ignored.
    supp     = '0;
    zero_run = lz_q;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run = zero_run && (data_q[4*i +: 4] == 4'h0);
      supp[i]  = zero_run;
    end

    cur_nib = data_q[{idx_q, 2'b00} +: 4];
    dark    = blank_q[idx_q] || supp[idx_q];

    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = '0;
    if (started_q) begin
      seg_d = dark ? 7'b0 : decode(cur_nib);
      dp_d  = dpin_q[idx_q] && !dark;
      an_d  = DIGITS'(1) << idx_q;
    end
    seg_d = seg_d ^ {7{ACTIVE_LOW}};
    dp_d  = dp_d ^ ACTIVE_LOW;
    an_d  = an_d ^ {DIGITS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
      data_q    <= '0;
      dpin_q    <= '0;
      blank_q   <= '0;
      lz_q      <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= {7{ACTIVE_LOW}};
      dp_q      <= ACTIVE_LOW;
      an_q      <= {DIGITS{ACTIVE_LOW}};
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      started_q <= 1'b1;
      frame_q   <= load;
      if (load) begin
        data_q  <= bus.data;
        dpin_q  <= bus.dp_in;
        blank_q <= bus.blank;
        lz_q    <= bus.lz_en;
      end
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (DIGITS=4, REFRESH_DIV=4); a second ACTIVE_LOW instance covers
// output polarity. Expected digit slots are queued when the stimulus for a frame is driven and
// popped as the scanner reaches each digit.
module tb_seg7_scan;

  localparam logic [6:0] SegF = 7'b1000111;
  localparam logic [6:0] SegA = 7'b1110111;
  localparam logic [6:0] Seg2 = 7'b1101101;
  localparam logic [6:0] Seg1 = 7'b0110000;
  localparam logic [6:0] Seg0 = 7'b1111110;
  localparam logic [6:0] Seg5 = 7'b1011011;
  localparam logic [6:0] Off  = 7'b0000000;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seg7_scan_if #(.DIGITS(4)) bus_a ();
  seg7_scan_if #(.DIGITS(4)) bus_b ();

  seg7_scan #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seg7_scan #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] an, input logic [6:0] seg,
                      input logic dp);
    exp_t e;
    e.tag = tag;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    sb.push_back(e);
  endtask

  task automatic push_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpv);
    push({tag, "_d0"}, 4'b0001, s0, dpv[0]);
    push({tag, "_d1"}, 4'b0010, s1, dpv[1]);
    push({tag, "_d2"}, 4'b0100, s2, dpv[2]);
    push({tag, "_d3"}, 4'b1000, s3, dpv[3]);
  endtask

  task automatic pop_compare(output logic [3:0] an_o);
    exp_t e;
    an_o = 'x;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL sb_empty: observed=empty expected=entry");
    end
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      an_o = e.an;
      chk({e.tag, "_an"}, 16'(bus_a.an), 16'(e.an));
      chk({e.tag, "_seg"}, 16'(bus_a.seg), 16'(e.seg));
      chk({e.tag, "_dp"}, 16'(bus_a.dp), 16'(e.dp));
    end
  endtask

  // Called at the first cycle of a digit slot; returns at the first cycle of the next slot.
  task automatic check_digit(input bit last);
    logic [3:0] held;
    pop_compare(held);
    chk("frame_low_start", 16'(bus_a.frame), 16'd0);
    repeat (3) @(negedge clk);
    chk("an_held", 16'(bus_a.an), 16'(held));
    chk(last ? "frame_pulse" : "frame_low_end", 16'(bus_a.frame), 16'(last));
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] dummy;
    bus_a.data  = 16'h12AF;
    bus_a.dp_in = 4'b0000;
    bus_a.blank = 4'b0000;
    bus_a.lz_en = 1'b0;
    bus_b.data  = 16'h0008;
    bus_b.dp_in = 4'b0000;
    bus_b.blank = 4'b0000;
    bus_b.lz_en = 1'b0;

    // Reset held three cycles: both instances dark at their physical levels.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_an", 16'(bus_a.an), 16'b0000);
      chk("rst_seg", 16'(bus_a.seg), 16'(Off));
      chk("rst_dp", 16'(bus_a.dp), 16'd0);
      chk("rst_frame", 16'(bus_a.frame), 16'd0);
      chk("rst_b_an", 16'(bus_b.an), 16'b1111);
      chk("rst_b_seg", 16'(bus_b.seg), 16'b1111111);
      chk("rst_b_dp", 16'(bus_b.dp), 16'd1);
    end
    push_frame("f1", Seg1, Seg2, SegA, SegF, 4'b0000);
    rst = 1'b0;

    @(negedge clk);
    chk("start_frame", 16'(bus_a.frame), 16'd1);
    chk("start_dark_an", 16'(bus_a.an), 16'b0000);
    @(negedge clk);
    chk("pol_b_an", 16'(bus_b.an), 16'b1110);
    chk("pol_b_seg", 16'(bus_b.seg), 16'b0000000);
    chk("pol_b_dp", 16'(bus_b.dp), 16'd1);

    // Frame 1: startup contents.
    check_digit(1'b0);
    push_frame("f2", Seg1, Seg2, SegA, SegF, 4'b0000);
    check_digit(1'b0);
    check_digit(1'b0);
    check_digit(1'b1);

    // Frame 2: data cleared while digit 1 is showing must not leak into digits 2/3.
    check_digit(1'b0);
    bus_a.data = 16'h0000;
    push_frame("f3", Seg0, Seg0, Seg0, Seg0, 4'b0000);
    check_digit(1'b0);
    check_digit(1'b0);
    check_digit(1'b1);

    // Frame 3: all zeros without suppression.
    check_digit(1'b0);
    bus_a.lz_en = 1'b1;
    bus_a.data  = 16'h0050;
    push_frame("f4_lz50", Off, Off, Seg5, Seg0, 4'b0000);
    check_digit(1'b0);
    check_digit(1'b0);
    check_digit(1'b1);

    // Frame 4: leading zeros above the 5 are dark.
    check_digit(1'b0);
    bus_a.data = 16'h0000;
    push_frame("f5_lz00", Off, Off, Off, Seg0, 4'b0000);
    check_digit(1'b0);
    check_digit(1'b0);
    check_digit(1'b1);

    // Frame 5: only digit 0 lit.
    check_digit(1'b0);
    bus_a.lz_en = 1'b0;
    bus_a.data  = 16'h12AF;
    bus_a.blank = 4'b0100;
    bus_a.dp_in = 4'b0101;
    push_frame("f6_blk", Seg1, Off, SegA, SegF, 4'b0001);
    check_digit(1'b0);
    check_digit(1'b0);
    check_digit(1'b1);

    // Frame 6: blanked digit 2 drops its dp too; then reset while digit 2 is enabled.
    check_digit(1'b0);
    bus_a.blank = 4'b0000;
    bus_a.dp_in = 4'b0000;
    check_digit(1'b0);
    pop_compare(dummy);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_an", 16'(bus_a.an), 16'b0000);
    chk("midrst_seg", 16'(bus_a.seg), 16'(Off));
    chk("midrst_dp", 16'(bus_a.dp), 16'd0);
    chk("midrst_frame", 16'(bus_a.frame), 16'd0);
    rst = 1'b0;
    push_frame("restart", Seg1, Seg2, SegA, SegF, 4'b0000);
    push("restart_next_d0", 4'b0001, SegF, 1'b0);

    @(negedge clk);
    chk("restart_frame", 16'(bus_a.frame), 16'd1);
    chk("restart_dark_an", 16'(bus_a.an), 16'b0000);
    @(negedge clk);
    check_digit(1'b0);
    check_digit(1'b0);
    check_digit(1'b0);
    check_digit(1'b1);
    pop_compare(dummy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
